// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch front end: widths, reset PC and PC step.
package fetch_stage_pkg;

    localparam int          ADDR_W       = 16;
    localparam int          INST_W       = 16;
    localparam int          IQ_DEPTH_DEF = 2;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam int          PC_INC       = 2;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {inst, pc} pairs between instruction memory and decode.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // NOTE: storage is left unreset; count gates every read, so its contents never matter while empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: credit-limited sequential PC requests, in-order response queue, redirect flush.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int            AW       = ADDR_W,
    parameter int            IQ_DEPTH = IQ_DEPTH_DEF,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [AW-1:0]     imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [AW-1:0]     redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [AW-1:0]     out_pc
);
    localparam int CW = $clog2(IQ_DEPTH + 1);

    logic [AW-1:0]        pc_q, pc_d;
    logic [CW-1:0]        in_flight_q, in_flight_d;
    logic [CW-1:0]        drop_q, drop_d;
    logic [CW-1:0]        q_count;
    logic [CW:0]          outstanding;
    logic                 req_ok, req_hs, rsp_drop, q_push, q_pop;
    logic [AW-1:0]        rsp_pc;
    logic [INST_W+AW-1:0] q_head;

    assign outstanding    = {1'b0, in_flight_q} + {1'b0, q_count};
    assign req_ok         = !halt && !redirect_valid && (outstanding < (CW+1)'(IQ_DEPTH));
    assign imem_req_valid = rst_n && req_ok;
    assign imem_req_addr  = pc_q;
    assign req_hs         = req_ok && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign q_push   = imem_rsp_valid && !rsp_drop && !redirect_valid;
    // Once stale responses are drained, every in-flight request is consecutive and ends just below pc_q.
    assign rsp_pc   = pc_q - AW'(PC_INC) * AW'(in_flight_q);

    assign out_valid = (q_count != '0);
    assign q_pop     = out_valid && out_ready;
    assign out_inst  = out_valid ? q_head[AW +: INST_W] : '0;
    assign out_pc    = out_valid ? q_head[AW-1:0] : '0;

    // NOTE: next-state logic uses blocking defaults so every path assigns a value and no latch forms.
    always_comb begin
        pc_d        = pc_q;
        in_flight_d = in_flight_q + CW'(req_hs) - CW'(imem_rsp_valid);
        drop_d      = drop_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            drop_d = in_flight_q - CW'(imem_rsp_valid);
        end else begin
            if (req_hs)   pc_d   = pc_q + AW'(PC_INC);
            if (rsp_drop) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            in_flight_q <= '0;
            drop_q      <= '0;
        end else begin
            pc_q        <= pc_d;
            in_flight_q <= in_flight_d;
            drop_q      <= drop_d;
        end
    end

    fetch_queue #(
        .DEPTH (IQ_DEPTH),
        .W     (INST_W + AW),
        .CW    (CW)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (q_push),
        .push_data_i ({imem_rsp_data, rsp_pc}),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .count_o     (q_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order, fixed-latency memory model returning ~addr.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data  = 16'h0;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;

    typedef struct { logic [15:0] addr; int due; } mreq_t;
    typedef struct { logic [15:0] pc; logic [15:0] inst; } del_t;

    mreq_t       mq[$];
    logic [15:0] req_log[$];
    del_t        del_log[$];
    int          lat    = 1;
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // Memory model and handshake monitor, evaluated late in each cycle once inputs have settled.
    always @(posedge clk) begin
        #3;
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'h0;
            cyc = 0;
        end else begin
            if (mq.size() != 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~mq[0].addr;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 16'h0;
            end
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc + lat});
                req_log.push_back(imem_req_addr);
            end
            if (out_valid && out_ready) del_log.push_back('{out_pc, out_inst});
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 after reset release.
    task automatic do_reset();
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        out_ready      = 1'b1;
        imem_req_ready = 1'b1;
        repeat (2) next_cycle();
        req_log.delete();
        del_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_del(input int n, input int budget, input string name);
        int k = 0;
        while (del_log.size() < n && k < budget) begin
            next_cycle();
            k++;
        end
        checks++; if (del_log.size() < n) begin errors++; $display("FAIL %s_timeout: deliveries=%0d required=%0d", name, del_log.size(), n); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        out_ready = 1'b1; imem_req_ready = 1'b1;
        #12;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 16'h0000) begin errors++; $display("FAIL rst_req_addr: got %h want 0000", imem_req_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_inst !== 16'h0000) begin errors++; $display("FAIL rst_out_inst: got %h want 0000", out_inst); end
        checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL rst_out_pc: got %h want 0000", out_pc); end
    endtask

    task automatic test_sequential();
        logic [15:0] exp_pc [4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        lat = 1;
        do_reset();
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL seq_c0_req_valid: got %b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 16'h0000) begin errors++; $display("FAIL seq_c0_req_addr: got %h want 0000", imem_req_addr); end
        next_cycle(); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_c1_out_valid: got %b want 0", out_valid); end
        checks++; if (imem_req_addr !== 16'h0002) begin errors++; $display("FAIL seq_c1_req_addr: got %h want 0002", imem_req_addr); end
        next_cycle(); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL seq_c2_out_valid: got %b want 1", out_valid); end
        checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL seq_c2_out_pc: got %h want 0000", out_pc); end
        checks++; if (out_inst !== 16'hFFFF) begin errors++; $display("FAIL seq_c2_out_inst: got %h want FFFF", out_inst); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL seq_c2_credit: got %b want 0", imem_req_valid); end
        next_cycle(); #1;
        checks++; if (out_pc !== 16'h0002) begin errors++; $display("FAIL seq_c3_out_pc: got %h want 0002", out_pc); end
        checks++; if (out_inst !== 16'hFFFD) begin errors++; $display("FAIL seq_c3_out_inst: got %h want FFFD", out_inst); end
        checks++; if (imem_req_addr !== 16'h0004 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL seq_c3_req: got %b/%h want 1/0004", imem_req_valid, imem_req_addr); end
        wait_del(4, 20, "seq");
        for (int i = 0; i < 4 && i < del_log.size(); i++) begin
            checks++; if (del_log[i].pc !== exp_pc[i] || del_log[i].inst !== ~exp_pc[i]) begin errors++; $display("FAIL seq_del%0d: got %h/%h want %h/%h", i, del_log[i].pc, del_log[i].inst, exp_pc[i], ~exp_pc[i]); end
        end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            checks++; if (req_log[i] !== exp_pc[i]) begin errors++; $display("FAIL seq_req%0d: got %h want %h", i, req_log[i], exp_pc[i]); end
        end
    endtask

    task automatic test_backpressure();
        lat = 1;
        do_reset();
        out_ready = 1'b0;
        repeat (6) next_cycle();
        #1;
        checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin errors++; $display("FAIL bp_head: got %b/%h want 1/0000", out_valid, out_pc); end
        out_ready = 1'b1;
        next_cycle(); #1;
        checks++; if (out_pc !== 16'h0002 || out_inst !== 16'hFFFD) begin errors++; $display("FAIL bp_second: got %h/%h want 0002/FFFD", out_pc, out_inst); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0004) begin errors++; $display("FAIL bp_resume: got %b/%h want 1/0004", imem_req_valid, imem_req_addr); end
        wait_del(3, 20, "bp");
        if (del_log.size() >= 3) begin
            checks++; if (del_log[0].pc !== 16'h0000 || del_log[1].pc !== 16'h0002 || del_log[2].pc !== 16'h0004) begin errors++; $display("FAIL bp_order: got %h,%h,%h want 0000,0002,0004", del_log[0].pc, del_log[1].pc, del_log[2].pc); end
        end
    endtask

    task automatic test_reset_mid();
        lat = 1;
        do_reset();
        out_ready = 1'b0;
        repeat (4) next_cycle();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_before: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 16'h0 || out_inst !== 16'h0) begin errors++; $display("FAIL midrst_out: got %b/%h/%h want 0/0000/0000", out_valid, out_pc, out_inst); end
        checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 16'h0) begin errors++; $display("FAIL midrst_req: got %b/%h want 0/0000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_stale();
        lat = 3;
        do_reset();
        repeat (2) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        #1;
        checks++; if (req_log.size() != 2) begin errors++; $display("FAIL stale_inflight: got %0d want 2", req_log.size()); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stale_redir_req: got %b want 0", imem_req_valid); end
        next_cycle();
        redirect_valid = 1'b0;
        wait_del(1, 30, "stale");
        repeat (8) next_cycle();
        for (int i = 0; i < del_log.size(); i++) begin
            checks++; if (del_log[i].pc !== 16'h0040 + 16'(2 * i) || del_log[i].inst !== ~(16'h0040 + 16'(2 * i))) begin errors++; $display("FAIL stale_del%0d: got %h/%h want %h", i, del_log[i].pc, del_log[i].inst, 16'h0040 + 16'(2 * i)); end
        end
        if (req_log.size() >= 3) begin
            checks++; if (req_log[2] !== 16'h0040) begin errors++; $display("FAIL stale_req2: got %h want 0040", req_log[2]); end
        end
    endtask

    task automatic test_redirect_coincident();
        lat = 1;
        do_reset();
        repeat (2) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0080;
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin errors++; $display("FAIL coin_head: got %b/%h want 1/0000", out_valid, out_pc); end
        checks++; if (imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL coin_rsp_present: got %b want 1", imem_rsp_valid); end
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL coin_flushed: got %b want 0", out_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0080) begin errors++; $display("FAIL coin_req: got %b/%h want 1/0080", imem_req_valid, imem_req_addr); end
        wait_del(2, 20, "coin");
        if (del_log.size() >= 2) begin
            checks++; if (del_log[0].pc !== 16'h0000) begin errors++; $display("FAIL coin_consumed: got %h want 0000", del_log[0].pc); end
            checks++; if (del_log[1].pc !== 16'h0080 || del_log[1].inst !== 16'hFF7F) begin errors++; $display("FAIL coin_target: got %h/%h want 0080/FF7F", del_log[1].pc, del_log[1].inst); end
        end
    endtask

    task automatic test_halt();
        lat = 3;
        do_reset();
        next_cycle();
        halt = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL halt_req_valid: got %b want 0", imem_req_valid); end
        wait_del(1, 10, "halt");
        next_cycle(); #1;
        checks++; if (req_log.size() != 1) begin errors++; $display("FAIL halt_req_count: got %0d want 1", req_log.size()); end
        if (del_log.size() >= 1) begin
            checks++; if (del_log[0].pc !== 16'h0000 || del_log[0].inst !== 16'hFFFF) begin errors++; $display("FAIL halt_drain: got %h/%h want 0000/FFFF", del_log[0].pc, del_log[0].inst); end
        end
        halt = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0002) begin errors++; $display("FAIL halt_resume: got %b/%h want 1/0002", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_pc_wrap();
        lat = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_redir_req: got %b want 0", imem_req_valid); end
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_req0: got %b/%h want 1/FFFE", imem_req_valid, imem_req_addr); end
        wait_del(2, 20, "wrap");
        if (req_log.size() >= 2) begin
            checks++; if (req_log[1] !== 16'h0000) begin errors++; $display("FAIL wrap_req1: got %h want 0000", req_log[1]); end
        end
        if (del_log.size() >= 2) begin
            checks++; if (del_log[0].pc !== 16'hFFFE || del_log[0].inst !== 16'h0001) begin errors++; $display("FAIL wrap_del0: got %h/%h want FFFE/0001", del_log[0].pc, del_log[0].inst); end
            checks++; if (del_log[1].pc !== 16'h0000 || del_log[1].inst !== 16'hFFFF) begin errors++; $display("FAIL wrap_del1: got %h/%h want 0000/FFFF", del_log[1].pc, del_log[1].inst); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_reset_mid();
        test_redirect_stale();
        test_redirect_coincident();
        test_halt();
        test_pc_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
